// File: rtl/kmac_intr_aggr_if.sv
// kmac_intr_aggr_if: single-cycle register bus between the CPU side (master) and the aggregator (slave).
// The slave answers every request one cycle later with an ack and registered read data.
interface kmac_intr_aggr_if;
    logic        reg_req;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    modport master (output reg_req, reg_wr, reg_addr, reg_wdata, input reg_ack, reg_rdata);
    modport slave (input reg_req, reg_wr, reg_addr, reg_wdata, output reg_ack, reg_rdata);
endinterface

// File: rtl/kmac_intr_aggr.sv
// kmac_intr_aggr: per-channel edge/level interrupt capture with enable, sticky W1C status,
// SW trigger and saturating event counters, folded into one registered global interrupt.
module kmac_intr_aggr #(
    parameter int                NUM_CH    = 4,
    parameter int                CNT_W     = 8,
    parameter logic [NUM_CH-1:0] EDGE_MODE = '1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] i_intr_src,
    kmac_intr_aggr_if.slave   bus,
    output logic [NUM_CH-1:0] o_sts,
    output logic              o_intr
);
    if (NUM_CH < 1 || NUM_CH > 12 || CNT_W < 1 || CNT_W > 32) begin : g_param_check
        $fatal(1, "kmac_intr_aggr: NUM_CH must be 1..12 and CNT_W 1..32");
    end

    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_sts;
    logic              r_gen;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic              r_ack;
    logic [31:0]       r_rdata;

    logic              w_wr;
    logic [NUM_CH-1:0] w_ev;
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_w1c;
    logic [NUM_CH-1:0] w_clr;
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [31:0]       w_rdata;

    assign w_wr  = bus.reg_req & bus.reg_wr;
    // Level channels ignore prev so they fire every cycle the source is high
    assign w_ev  = i_intr_src & ~(r_prev & EDGE_MODE);
    assign w_set = (w_ev & r_en) | ((w_wr && bus.reg_addr == 4'h2) ? bus.reg_wdata[NUM_CH-1:0] : '0);
    assign w_w1c = (w_wr && bus.reg_addr == 4'h1) ? bus.reg_wdata[NUM_CH-1:0] : '0;

    // Clear is applied first so a clear plus an increment lands on 1
    always_comb begin
        w_clr     = '0;
        w_cnt_nxt = r_cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            w_clr[i]     = w_wr && bus.reg_addr == 4'(i + 4);
            w_cnt_nxt[i] = w_clr[i] ? '0 : r_cnt[i];
            w_cnt_nxt[i] = (w_set[i] && !(&w_cnt_nxt[i])) ? w_cnt_nxt[i] + 1'b1 : w_cnt_nxt[i];
        end
    end

    always_comb begin
        w_rdata = bus.reg_addr == 4'h0 ? 32'(r_en)  :
                  bus.reg_addr == 4'h1 ? 32'(r_sts) :
                  bus.reg_addr == 4'h3 ? 32'(r_gen) : '0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.reg_addr == 4'(i + 4)) w_rdata = 32'(r_cnt[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev  <= '0;
            r_en    <= '0;
            r_sts   <= '0;
            r_gen   <= 1'b0;
            r_cnt   <= '{default: '0};
            r_ack   <= 1'b0;
            r_rdata <= '0;
            o_intr  <= 1'b0;
        end else begin
            r_prev  <= i_intr_src;
            r_sts   <= (r_sts & ~w_w1c) | w_set;
            r_cnt   <= w_cnt_nxt;
            if (w_wr && bus.reg_addr == 4'h0) r_en <= bus.reg_wdata[NUM_CH-1:0];
            if (w_wr && bus.reg_addr == 4'h3) r_gen <= bus.reg_wdata[0];
            r_ack   <= bus.reg_req;
            r_rdata <= (bus.reg_req && !bus.reg_wr) ? w_rdata : '0;
            // Built from registered status, so it trails a status set by one cycle
            o_intr  <= r_gen & |(r_sts & r_en);
        end
    end

    assign o_sts         = r_sts;
    assign bus.reg_ack   = r_ack;
    assign bus.reg_rdata = r_rdata;
endmodule

// File: tb/tb_kmac_intr_aggr.sv
// tb_kmac_intr_aggr: directed scenarios plus random traffic; a reference model predicts every cycle's
// bus response, status and interrupt, and a monitor compares them against the DUT.
module tb_kmac_intr_aggr;
    localparam int NCH = 4;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [NCH-1:0] EM = 4'b1101;

    typedef struct packed {
        logic        ack;
        logic [31:0] rdata;
        logic        intr;
        logic [3:0]  sts;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NCH-1:0] src = '0;
    logic [NCH-1:0] o_sts;
    logic o_intr;
    logic [NCH-1:0] cur_src = '0;

    kmac_intr_aggr_if bus();

    kmac_intr_aggr #(.NUM_CH(NCH), .CNT_W(CW), .EDGE_MODE(EM)) dut (
        .clk(clk), .reset_n(reset_n), .i_intr_src(src), .bus(bus), .o_sts(o_sts), .o_intr(o_intr)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    logic [NCH-1:0] m_en, m_sts, m_prev;
    logic m_gen;
    int m_cnt [NCH];

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 0) return 32'(m_en);
        if (a == 1) return 32'(m_sts);
        if (a == 3) return 32'(m_gen);
        if (a >= 4 && a < 4 + NCH) return 32'(m_cnt[a - 4]);
        return 32'd0;
    endfunction

    task automatic model_clear();
        m_en = '0; m_sts = '0; m_prev = '0; m_gen = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endtask

    task automatic cyc(input logic [NCH-1:0] s, input logic rq = 1'b0, input logic w = 1'b0,
                       input logic [3:0] a = 4'd0, input logic [31:0] d = 32'd0);
        exp_t e;
        logic ev, st;
        logic is_wr;
        @(negedge clk);
        reset_n = 1'b1;
        src = s;
        cur_src = s;
        bus.reg_req = rq; bus.reg_wr = w; bus.reg_addr = a; bus.reg_wdata = d;
        is_wr = rq && w;
        e.ack = rq;
        e.rdata = (rq && !w) ? m_read(a) : 32'd0;
        e.intr = m_gen && |(m_sts & m_en);
        for (int i = 0; i < NCH; i++) begin
            ev = EM[i] ? (s[i] && !m_prev[i]) : s[i];
            st = (ev && m_en[i]) || (is_wr && a == 2 && d[i]);
            if (is_wr && a == 1 && d[i]) m_sts[i] = 1'b0;
            if (st) m_sts[i] = 1'b1;
            if (is_wr && a == 4 + i) m_cnt[i] = 0;
            if (st && m_cnt[i] < CMAX) m_cnt[i]++;
        end
        if (is_wr && a == 0) m_en = d[NCH-1:0];
        if (is_wr && a == 3) m_gen = d[0];
        m_prev = s;
        e.sts = m_sts;
        q.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(cur_src, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(cur_src, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n = 1);
        repeat (n) cyc(cur_src);
    endtask

    task automatic rst_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            reset_n = 1'b0;
            bus.reg_req = 1'b0;
            model_clear();
            q.push_back('0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({bus.reg_ack, bus.reg_rdata, o_intr, o_sts} === e) passes++;
                else $display("FAIL cycle_chk @%0t: got ack=%0b rdata=%0h intr=%0b sts=%0h, want ack=%0b rdata=%0h intr=%0b sts=%0h",
                              $time, bus.reg_ack, bus.reg_rdata, o_intr, o_sts, e.ack, e.rdata, e.intr, e.sts);
            end
        end
    end

    initial begin : stim
        bus.reg_req = 1'b0; bus.reg_wr = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
        model_clear();
        rst_cyc(2);
        for (int a = 0; a < 16; a++) rd(4'(a));
        // edge channel 0
        wr(3, 1); wr(0, 1);
        repeat (5) cyc(4'b0001);
        cur_src = 4'b0000; idle(2);
        rd(1); rd(4);
        wr(1, 1); idle(2);
        // level channel 1 with a W1C mid-pulse
        wr(0, 2);
        cyc(4'b0010); cyc(4'b0010);
        cur_src = 4'b0010; wr(1, 2);
        cyc(4'b0010);
        cur_src = 4'b0000; idle(2);
        rd(5); rd(1); wr(1, 2); idle(1);
        // simultaneous W1C and edge; counter clear with increment
        wr(0, 1); idle(1);
        cur_src = 4'b0001; wr(1, 1);
        cur_src = 4'b0000; idle(1);
        rd(1); rd(4);
        cur_src = 4'b0001; wr(4, 32'hFFFF_FFFF);
        cur_src = 4'b0000; idle(1);
        rd(4);
        // saturation on channel 0
        repeat (10) begin cyc(4'b0001); cyc(4'b0000); end
        rd(4); cyc(4'b0001); cyc(4'b0000); rd(4);
        // SW trigger on channel 2
        wr(0, 4); wr(2, 4); idle(2); rd(1);
        // global and per-channel masking
        wr(3, 0); idle(2); wr(3, 1); idle(2);
        wr(0, 0);
        repeat (3) begin cyc(4'b1111); cyc(4'b0000); end
        rd(1); rd(4); rd(5); rd(6); rd(7);
        // reset mid-pulse, source still high on release
        wr(0, 1); wr(3, 1); cyc(4'b0001); cyc(4'b0001);
        rst_cyc(2);
        cyc(4'b0001); idle(1);
        for (int a = 0; a < 8; a++) rd(4'(a));
        rd(4'hF);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic rq, w;
            logic [3:0] a;
            logic [31:0] d;
            rq = ($urandom_range(0, 2) != 0);
            w = $urandom_range(0, 1);
            a = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if (n == 300) rst_cyc(1);
            cyc(4'($urandom_range(0, 15)), rq, w, a, d);
        end
        idle(1);
        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
